// File: rtl/as_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : as_cmd_scheduler_pkg
// Description : Shared defaults and FSM state encoding for the command-queue
//               front end of the upsample/route address sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package as_cmd_scheduler_pkg;

  // Default field widths and queue depth.
  localparam int unsigned DEF_W_SIZE    = 9;
  localparam int unsigned DEF_W_CHANNEL = 11;
  localparam int unsigned DEF_FM_AW     = 16;
  localparam int unsigned DEF_TAG_W     = 4;
  localparam int unsigned DEF_CMD_DEPTH = 4;

  // Scheduler FSM: pop -> check -> start pulse -> wait for done.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHK   = 2'd1,
    ST_START = 2'd2,
    ST_BUSY  = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/as_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : as_cmd_fifo
// Description : Synchronous show-ahead command FIFO. Pointers carry an extra
//               wrap bit to tell full from empty; ready is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module as_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  output logic             o_rdy,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic [c_aw:0]    w_wr_ptr_nxt;
  logic [c_aw:0]    w_rd_ptr_nxt;
  logic             r_rdy;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full_nxt;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_push       = i_push & r_rdy;
  assign w_pop        = i_pop & ~w_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + {{c_aw{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{c_aw{1'b0}}, w_pop};
  // Full when the pointers point at the same slot but on different laps.
  assign w_full_nxt   = (w_wr_ptr_nxt[c_aw] != w_rd_ptr_nxt[c_aw]) &&
                        (w_wr_ptr_nxt[c_aw-1:0] == w_rd_ptr_nxt[c_aw-1:0]);

  assign o_rdy     = r_rdy;
  assign o_empty   = w_empty;
  assign o_rd_data = r_mem[r_rd_ptr[c_aw-1:0]];

  // Pointer and ready registers; ready reflects fullness after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rdy    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_rdy    <= ~w_full_nxt;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/as_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : as_cmd_scheduler
// Description : Queues packed layer commands, then runs them one at a time:
//               latch fields, validate, compute row stride, pulse start,
//               wait for done and report completion with the command tag.
// Revision    : 1.0 - initial release
// ============================================================================
module as_cmd_scheduler
  import as_cmd_scheduler_pkg::*;
#(
  parameter int W_SIZE    = DEF_W_SIZE,
  parameter int W_CHANNEL = DEF_W_CHANNEL,
  parameter int FM_AW     = DEF_FM_AW,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int CMD_DEPTH = DEF_CMD_DEPTH,
  localparam int CMD_W    = 1 + 2*W_SIZE + 3*W_CHANNEL + FM_AW + TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cmd_vld,
  output logic                    o_cmd_rdy,
  input  logic [CMD_W-1:0]        i_cmd_data,
  output logic                    o_cmd_done,
  output logic                    o_cmd_err,
  output logic [TAG_W-1:0]        o_cmd_tag,
  output logic                    o_busy,
  output logic                    q_as_mode,
  output logic [W_SIZE-1:0]       q_width,
  output logic [W_SIZE-1:0]       q_height,
  output logic [W_CHANNEL-1:0]    q_channel,
  output logic [W_CHANNEL-1:0]    q_channel_out,
  output logic [W_SIZE+W_CHANNEL-1:0] q_row_stride,
  output logic [FM_AW-1:0]        q_route_offset,
  output logic [W_CHANNEL-1:0]    q_route_chn_offset,
  output logic                    q_as_start,
  input  logic                    i_as_done
);

  // Command field positions, LSB first.
  localparam int c_mode_lsb  = 0;
  localparam int c_width_lsb = c_mode_lsb + 1;
  localparam int c_hght_lsb  = c_width_lsb + W_SIZE;
  localparam int c_chan_lsb  = c_hght_lsb + W_SIZE;
  localparam int c_chout_lsb = c_chan_lsb + W_CHANNEL;
  localparam int c_roff_lsb  = c_chout_lsb + W_CHANNEL;
  localparam int c_rchn_lsb  = c_roff_lsb + FM_AW;
  localparam int c_tag_lsb   = c_rchn_lsb + W_CHANNEL;

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [CMD_W-1:0] w_head;
  logic             w_empty;
  logic             w_pop;
  logic             w_set_start;
  logic             w_set_done;
  logic             w_set_err;
  logic             w_load_stride;
  logic             w_cmd_bad;
  logic             r_done_seen;
  logic [TAG_W-1:0] r_tag;
  logic [W_CHANNEL:0] w_route_top;

  as_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (i_cmd_vld),
    .o_rdy     (o_cmd_rdy),
    .i_wr_data (i_cmd_data),
    .i_pop     (w_pop),
    .o_empty   (w_empty),
    .o_rd_data (w_head)
  );

  // Route writes span [route_chn_offset, route_chn_offset+channel); one extra bit avoids wrap.
  assign w_route_top = {1'b0, q_channel} + {1'b0, q_route_chn_offset};
  assign w_cmd_bad   = (q_width == '0) || (q_height == '0) || (q_channel == '0) ||
                       (q_channel_out < q_channel) ||
                       (q_as_mode && ({1'b0, q_channel_out} < w_route_top));

  assign o_busy = ~w_empty || (r_state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_set_start   = 1'b0;
    w_set_done    = 1'b0;
    w_set_err     = 1'b0;
    w_load_stride = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_CHK;
        end
      end
      ST_CHK: begin
        if (w_cmd_bad) begin
          w_set_done  = 1'b1;
          w_set_err   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_load_stride = 1'b1;
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        w_set_start = 1'b1;
        w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (r_done_seen) begin
          w_set_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer done is only meaningful while a command is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_seen <= 1'b0;
    end else begin
      r_done_seen <= i_as_done && (r_state == ST_BUSY);
    end
  end

  // Registered outputs: config latched on pop, pulses for start/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cmd_done         <= 1'b0;
      o_cmd_err          <= 1'b0;
      o_cmd_tag          <= '0;
      q_as_start         <= 1'b0;
      q_as_mode          <= 1'b0;
      q_width            <= '0;
      q_height           <= '0;
      q_channel          <= '0;
      q_channel_out      <= '0;
      q_row_stride       <= '0;
      q_route_offset     <= '0;
      q_route_chn_offset <= '0;
      r_tag              <= '0;
    end else begin
      o_cmd_done <= w_set_done;
      o_cmd_err  <= w_set_err;
      q_as_start <= w_set_start;
      if (w_set_done) begin
        o_cmd_tag <= r_tag;
      end
      if (w_pop) begin
        q_as_mode          <= w_head[c_mode_lsb];
        q_width            <= w_head[c_width_lsb +: W_SIZE];
        q_height           <= w_head[c_hght_lsb  +: W_SIZE];
        q_channel          <= w_head[c_chan_lsb  +: W_CHANNEL];
        q_channel_out      <= w_head[c_chout_lsb +: W_CHANNEL];
        q_route_offset     <= w_head[c_roff_lsb  +: FM_AW];
        q_route_chn_offset <= w_head[c_rchn_lsb  +: W_CHANNEL];
        r_tag              <= w_head[c_tag_lsb   +: TAG_W];
      end
      if (w_load_stride) begin
        q_row_stride <= {{W_CHANNEL{1'b0}}, q_width} * {{W_SIZE{1'b0}}, q_channel};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_as_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_as_cmd_scheduler
// Description : Self-checking bench for as_cmd_scheduler: timing-rule model
//               compared every cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_as_cmd_scheduler;

  typedef struct packed {
    logic [3:0]  tag;
    logic [10:0] rco;
    logic [15:0] ro;
    logic [10:0] co;
    logic [10:0] c;
    logic [8:0]  h;
    logic [8:0]  w;
    logic        mode;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_vld = 1'b0;
  cmd_t        drv_cmd = '0;
  logic        i_as_done = 1'b0;
  logic        o_cmd_rdy, o_cmd_done, o_cmd_err, o_busy, q_as_mode, q_as_start;
  logic [3:0]  o_cmd_tag;
  logic [8:0]  q_width, q_height;
  logic [10:0] q_channel, q_channel_out, q_route_chn_offset;
  logic [19:0] q_row_stride;
  logic [15:0] q_route_offset;

  as_cmd_scheduler dut (
    .clk(clk), .rst(rst), .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy),
    .i_cmd_data(drv_cmd), .o_cmd_done(o_cmd_done), .o_cmd_err(o_cmd_err),
    .o_cmd_tag(o_cmd_tag), .o_busy(o_busy), .q_as_mode(q_as_mode),
    .q_width(q_width), .q_height(q_height), .q_channel(q_channel),
    .q_channel_out(q_channel_out), .q_row_stride(q_row_stride),
    .q_route_offset(q_route_offset), .q_route_chn_offset(q_route_chn_offset),
    .q_as_start(q_as_start), .i_as_done(i_as_done)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input int m, input int w, input int h, input int c,
                              input int co, input int ro, input int rco, input int tag);
    cmd_t x;
    x.mode = 1'(m);  x.w  = 9'(w);   x.h   = 9'(h);   x.c   = 11'(c);
    x.co   = 11'(co); x.ro = 16'(ro); x.rco = 11'(rco); x.tag = 4'(tag);
    return x;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t x;
    x = mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 40)), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    if ($urandom_range(0, 9) == 0) begin
      x.w = 9'd511; x.c = 11'(2047 - int'($urandom_range(0, 3))); x.co = 11'd2047; x.rco = '0;
    end
    return x;
  endfunction

  // A command runs only if every size is non-zero and the output pitch covers the channels written.
  function automatic bit cmd_ok(input cmd_t x);
    return (x.w != 0) && (x.h != 0) && (x.c != 0) && (int'(x.co) >= int'(x.c)) &&
           !(x.mode && (int'(x.co) < int'(x.c) + int'(x.rco)));
  endfunction

  // ---------------- reference model (edge-indexed timing rules) ----------------
  cmd_t        mq[$];
  cmd_t        m_cur;
  cmd_t        e_cmd = '0;
  bit          m_active = 0, m_valid = 0, m_rdy = 0;
  int          m_pop = 0, m_dn = -1, m_next_pop = 0, n = 0;
  bit          e_start = 0, e_done = 0, e_err = 0;
  logic [3:0]  e_tag = '0;
  logic [19:0] e_stride = '0;

  initial forever begin
    @(posedge clk);
    n++;
    if (rst) begin
      mq.delete(); m_active = 0; m_rdy = 0; m_next_pop = 0; m_dn = -1;
      e_start = 0; e_done = 0; e_err = 0; e_cmd = '0; e_stride = '0;
    end else begin
      int  sz_pre;
      bit  rdy_pre;
      sz_pre  = mq.size();
      rdy_pre = m_rdy;
      e_start = 0; e_done = 0; e_err = 0;
      if (m_active) begin
        if (!m_valid) begin
          if (n == m_pop + 1) begin
            e_done = 1; e_err = 1; e_tag = m_cur.tag; m_active = 0; m_next_pop = n + 1;
          end
        end else begin
          if (n == m_pop + 1) e_stride = 20'(int'(m_cur.w) * int'(m_cur.c));
          if (n == m_pop + 2) e_start = 1;
          if (m_dn >= 0 && n == m_dn + 1) begin
            e_done = 1; e_tag = m_cur.tag; m_active = 0; m_next_pop = n + 1;
          end else if (m_dn < 0 && n >= m_pop + 3 && i_as_done) begin
            m_dn = n;
          end
        end
      end
      if (!m_active && n >= m_next_pop && sz_pre > 0) begin
        m_cur = mq.pop_front(); e_cmd = m_cur; m_valid = cmd_ok(m_cur);
        m_active = 1; m_pop = n; m_dn = -1;
      end
      if (i_cmd_vld && rdy_pre) mq.push_back(drv_cmd);
      m_rdy = (mq.size() < 4);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("rdy",     64'(o_cmd_rdy),  64'(m_rdy));
      check("busy",    64'(o_busy),     64'((mq.size() > 0) || m_active));
      check("start",   64'(q_as_start), 64'(e_start));
      check("done",    64'(o_cmd_done), 64'(e_done));
      check("err",     64'(o_cmd_err),  64'(e_err));
      if (e_done) check("tag", 64'(o_cmd_tag), 64'(e_tag));
      check("mode",    64'(q_as_mode),          64'(e_cmd.mode));
      check("width",   64'(q_width),            64'(e_cmd.w));
      check("height",  64'(q_height),           64'(e_cmd.h));
      check("channel", 64'(q_channel),          64'(e_cmd.c));
      check("ch_out",  64'(q_channel_out),      64'(e_cmd.co));
      check("r_off",   64'(q_route_offset),     64'(e_cmd.ro));
      check("r_chn",   64'(q_route_chn_offset), 64'(e_cmd.rco));
      check("stride",  64'(q_row_stride),       64'(e_stride));
    end
  end

  // ---------------- observers ----------------
  logic [4:0] done_log[$];
  int         n_starts = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (o_cmd_done) done_log.push_back({o_cmd_err, o_cmd_tag});
      if (q_as_start) n_starts++;
    end
  end

  // ---------------- sequencer stand-in ----------------
  // 0: never done, 1: done seq_lat cycles after start, 2: random, 3: one pulse
  int seq_mode = 0;
  int seq_lat  = 2;
  initial begin
    int cnt;
    bit kicked;
    cnt = -1; kicked = 0;
    forever begin
      @(negedge clk);
      i_as_done = 1'b0;
      if (rst) begin
        cnt = -1; kicked = 0;
      end else begin
        case (seq_mode)
          1: begin
            kicked = 0;
            if (cnt == 0) begin i_as_done = 1'b1; cnt = -1; end
            else if (cnt > 0) cnt--;
            if (q_as_start) cnt = seq_lat;
          end
          2: begin kicked = 0; cnt = -1; i_as_done = ($urandom_range(0, 5) == 0); end
          3: begin i_as_done = !kicked; kicked = 1; cnt = -1; end
          default: begin kicked = 0; cnt = -1; end
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic push(input cmd_t c, output int acc_n);
    int t;
    t = 0;
    drv_cmd = c; i_cmd_vld = 1'b1;
    while (!o_cmd_rdy && t < 300) begin @(negedge clk); t++; end
    check("push_timeout", 64'(t < 300), 64'(1));
    @(negedge clk);
    i_cmd_vld = 1'b0;
    acc_n = n;
  endtask

  task automatic wait_dones(input int target);
    int t;
    t = 0;
    while (done_log.size() < target && t < 600) begin @(negedge clk); t++; end
    check("done_timeout", 64'(done_log.size() >= target), 64'(1));
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (!q_as_start && t < 50) begin @(negedge clk); t++; end
    check("start_timeout", 64'(q_as_start), 64'(1));
  endtask

  initial begin
    int acc, d0, s0, k, accepted, t;
    bit took;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_rdy",    64'(o_cmd_rdy),    64'(0));
    check("rst_busy",   64'(o_busy),       64'(0));
    check("rst_done",   64'(o_cmd_done),   64'(0));
    check("rst_start",  64'(q_as_start),   64'(0));
    check("rst_stride", 64'(q_row_stride), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 64'(o_cmd_rdy), 64'(1));

    // Upsample 4x4x8 -> start three edges after accept, stride 32
    seq_mode = 1; seq_lat = 2;
    d0 = done_log.size();
    push(mk(0, 4, 4, 8, 8, 0, 0, 3), acc);
    wait_start();
    check("t1_start_latency", 64'(n - acc), 64'(3));
    check("t1_stride",        64'(q_row_stride), 64'(32));
    wait_dones(d0 + 1);
    check("t1_done_word", 64'(done_log[d0]), 64'(5'b0_0011));

    // Route, exactly fitting channel window
    s0 = n_starts; d0 = done_log.size();
    push(mk(1, 2, 2, 4, 12, 100, 8, 5), acc);
    wait_dones(d0 + 1);
    check("route_ok_word",   64'(done_log[d0]), 64'(5'b0_0101));
    check("route_ok_starts", 64'(n_starts - s0), 64'(1));
    // Route, one channel past the window
    s0 = n_starts; d0 = done_log.size();
    push(mk(1, 2, 2, 4, 12, 100, 9, 6), acc);
    wait_dones(d0 + 1);
    check("route_bad_word",   64'(done_log[d0]), 64'(5'b1_0110));
    check("route_bad_starts", 64'(n_starts - s0), 64'(0));

    // Backpressure while one command is held busy
    seq_mode = 0;
    s0 = n_starts; d0 = done_log.size();
    push(mk(0, 3, 3, 5, 6, 0, 0, 9), acc);
    wait_start();
    k = 0; accepted = 0;
    drv_cmd = mk(0, 2, 2, 3, 3, 0, 0, 0); i_cmd_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      took = o_cmd_rdy;
      @(negedge clk);
      if (took) begin accepted++; k++; drv_cmd = mk(0, 2, 2, 3, 3, 0, 0, k); end
    end
    check("bp_accepted", 64'(accepted), 64'(4));
    check("bp_rdy_low",  64'(o_cmd_rdy), 64'(0));
    seq_lat = 10; seq_mode = 3;
    @(negedge clk); @(negedge clk);
    seq_mode = 1;
    t = 0;
    while (t < 200) begin
      took = o_cmd_rdy;
      @(negedge clk); t++;
      if (took) break;
    end
    i_cmd_vld = 1'b0;
    check("bp_fifth_taken", 64'(t < 200), 64'(1));
    wait_dones(d0 + 6);
    check("bp_order_0", 64'(done_log[d0]),     64'(5'b0_1001));
    for (int i = 1; i < 6; i++) check("bp_order", 64'(done_log[d0 + i]), 64'(i - 1));
    check("bp_starts", 64'(n_starts - s0), 64'(6));

    // Zero-width command between two valid ones
    seq_lat = 3; d0 = done_log.size();
    push(mk(0, 4, 2, 2, 2, 0, 0, 10), acc);
    push(mk(0, 0, 2, 2, 2, 0, 0, 11), acc);
    push(mk(0, 4, 2, 2, 2, 0, 0, 12), acc);
    wait_dones(d0 + 3);
    check("zw_first",  64'(done_log[d0]),     64'(5'b0_1010));
    check("zw_middle", 64'(done_log[d0 + 1]), 64'(5'b1_1011));
    check("zw_last",   64'(done_log[d0 + 2]), 64'(5'b0_1100));

    // Reset while busy with two queued
    seq_mode = 0;
    push(mk(0, 2, 2, 2, 2, 0, 0, 1), acc);
    push(mk(0, 2, 2, 2, 2, 0, 0, 2), acc);
    push(mk(0, 2, 2, 2, 2, 0, 0, 3), acc);
    wait_start();
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  64'(o_busy),       64'(0));
    check("mid_rst_rdy",   64'(o_cmd_rdy),    64'(0));
    check("mid_rst_width", 64'(q_width),      64'(0));
    check("mid_rst_strd",  64'(q_row_stride), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    d0 = done_log.size();
    repeat (6) @(negedge clk);
    check("post_rst_no_done", 64'(done_log.size()), 64'(d0));
    check("post_rst_busy",    64'(o_busy),           64'(0));
    seq_mode = 1; seq_lat = 1;
    push(mk(1, 3, 1, 2, 7, 40, 5, 13), acc);
    wait_dones(d0 + 1);
    check("post_rst_word", 64'(done_log[d0]), 64'(5'b0_1101));

    // Randomized traffic
    seq_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      drv_cmd   = rand_cmd();
      i_cmd_vld = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    i_cmd_vld = 1'b0;
    t = 0;
    while (o_busy && t < 3000) begin @(negedge clk); t++; end
    check("drain_idle", 64'(o_busy), 64'(0));
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
